bitmask_rightmost_bit_iterator: RTL and testbench
=================================================

BITMASK_RIGHTMOST_BIT_ITERATOR -- requirements
Module: bitmask_rightmost_bit_iterator

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8, meaning data word width in bits (minimum 2).
REQ-002 SHALL have derived localparam INDEX_WIDTH = clog2(WORD_WIDTH), meaning bit-index width.
REQ-003 SHALL have port clock  input  1  meaning single clock, all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  meaning reset, asynchronous, active-low.
REQ-005 SHALL have port input_valid  input  1  meaning input word and mode offered.
REQ-006 SHALL have port input_ready  output  1  meaning block accepts input this cycle.
REQ-007 SHALL have port input_word  input  WORD_WIDTH  meaning operand.
REQ-008 SHALL have port input_mode  input  2  meaning operation select, encoded per REQ-013.
REQ-009 SHALL have port output_valid  output  1  meaning output_word is valid.
REQ-010 SHALL have port output_ready  input  1  meaning consumer accepts output this cycle.
REQ-011 SHALL have port output_word  output  WORD_WIDTH  meaning result bitmask.
REQ-012 SHALL have port output_last  output  1  meaning final output for the accepted input.

Function
REQ-013 SHALL decode input_mode as: 0 TRAIL0 = ~x & (x-1); 1 ISOLATE1 = x & (-x); 2 TRAIL0_AND_1 = x ^ (x-1); 3 ITERATE.
REQ-014 SHALL perform all arithmetic modulo 2^WORD_WIDTH, with x-1 of zero equal to all-ones.
REQ-015 SHALL accept an input only on a cycle where input_valid and input_ready are both high.
REQ-016 SHALL run a two-state FSM: IDLE (no output held) and BUSY (output register valid).
REQ-017 SHALL in IDLE drive input_ready high, and on accept move to BUSY with output_valid high on the next cycle (latency 1).
REQ-018 SHALL in modes 0-2 produce exactly one output with output_last=1.
REQ-019 SHALL in ITERATE load a residual register with x and emit the isolated lowest set bit of the residual, one output per output handshake, lowest bit first.
REQ-020 SHALL on each ITERATE output handshake clear the emitted bit from the residual, with output_last=1 when the residual holds exactly one set bit.
REQ-021 SHALL in ITERATE with x=0 emit one output word of 0 with output_last=1.
REQ-022 SHALL in BUSY drive input_ready = output_ready & output_last, so that a new accept on the final handshake moves directly to the new result with no bubble.
REQ-023 SHALL return to IDLE on a final-output handshake with no simultaneous accept.
REQ-024 SHALL hold output_word, output_last and output_valid stable while output_valid=1 and output_ready=0.
REQ-025 SHALL ignore input_word and input_mode when input_valid=0 or input_ready=0.

Reset
REQ-026 SHALL on reset_n low immediately force: FSM to IDLE, output_valid=0, output_word=0, output_last=0, residual=0, input_ready=1 once released.
REQ-027 SHALL discard any in-progress iteration on reset, emitting no further outputs for it.

Configuration
REQ-028 SHALL, with macro BITMASK_ITERATOR_INDEX_EN defined, add port output_index  output  INDEX_WIDTH, giving the binary position of the single set bit of output_word in ISOLATE1 and ITERATE modes, and the trailing-zero count of x in TRAIL0 and TRAIL0_AND_1 modes, with reset value 0.
REQ-029 SHALL, with BITMASK_ITERATOR_INDEX_EN undefined, omit output_index and all encoder logic, with behaviour otherwise identical.
REQ-030 SHALL define output_index as 0 whenever output_word is 0.

Structure
REQ-031 SHALL place the mode encoding and the FSM state encoding in shared package bitmask_pkg.
REQ-032 SHALL implement the four combinational operations in one sub-module, bitmask_rightmost_bit_ops (word in, mode in, mask out).

Verification
REQ-033 SHALL cover: WORD_WIDTH=8, mode0, x=01011000 -> one output 00000111 with last=1, one cycle after accept.
REQ-034 SHALL cover: mode1, x=01011000 -> 00001000; mode2, x=01011000 -> 00001111; each with last=1.
REQ-035 SHALL cover: mode3, x=01011000 with output_ready=1 -> 00001000, 00010000, 01000000 on consecutive cycles, last=1 on the third only; with INDEX_EN, indices 3, 4, 6.
REQ-036 SHALL cover: mode3, x=0 -> single output 00000000, last=1; mode0, x=0 -> 11111111; mode1, x=0 -> 00000000.
REQ-037 SHALL cover: output_ready held low 5 cycles during ITERATE -> output stable, input_ready=0; back-to-back mode0 inputs with output_ready=1 -> one output per cycle, no bubble.
REQ-038 SHALL cover: reset_n asserted after the second output of a mode3 x=11110000 run -> output_valid=0 immediately, and no remaining outputs after release.

Source files
------------

// File: rtl/bitmask_pkg.sv
// Shared encodings for the rightmost-bit iterator: operation select and FSM state.
package bitmask_pkg;

    typedef enum logic [1:0] {
        MODE_TRAIL0       = 2'd0,
        MODE_ISOLATE1     = 2'd1,
        MODE_TRAIL0_AND_1 = 2'd2,
        MODE_ITERATE      = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/bitmask_rightmost_bit_ops.sv
// Combinational rightmost-bit operations; ITERATE shares the isolate-lowest-bit datapath.
module bitmask_rightmost_bit_ops
    import bitmask_pkg::*;
#(
    parameter int WORD_WIDTH = 8
) (
    input  logic [WORD_WIDTH-1:0] word_i,
    input  logic [1:0]            mode_i,
    output logic [WORD_WIDTH-1:0] mask_o
);

    localparam logic [WORD_WIDTH-1:0] ONE = WORD_WIDTH'(1);

    logic [WORD_WIDTH-1:0] dec;
    logic [WORD_WIDTH-1:0] neg;

    // Wrap-around is intended: decrementing zero yields all-ones.
    assign dec = word_i - ONE;
    assign neg = ~word_i + ONE;

    // NOTE: default assignment first so every path drives mask_o and no latch is inferred.
    always_comb begin
        mask_o = '0;
        case (mode_e'(mode_i))
            MODE_TRAIL0:                 mask_o = ~word_i & dec;
            MODE_TRAIL0_AND_1:           mask_o = word_i ^ dec;
            MODE_ISOLATE1, MODE_ITERATE: mask_o = word_i & neg;
            default:                     mask_o = '0;
        endcase
    end

endmodule

// File: rtl/bitmask_rightmost_bit_iterator.sv
// Valid/ready rightmost-bit unit: single-result modes plus a lowest-bit-first set-bit iterator.
// Define BITMASK_ITERATOR_INDEX_EN to add the output_index port and its position encoder.
module bitmask_rightmost_bit_iterator
    import bitmask_pkg::*;
#(
    parameter  int WORD_WIDTH  = 8,
    localparam int INDEX_WIDTH = $clog2(WORD_WIDTH)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  input_valid,
    output logic                  input_ready,
    input  logic [WORD_WIDTH-1:0] input_word,
    input  logic [1:0]            input_mode,
    output logic                  output_valid,
    input  logic                  output_ready,
    output logic [WORD_WIDTH-1:0] output_word,
    output logic                  output_last
`ifdef BITMASK_ITERATOR_INDEX_EN
    ,
    output logic [INDEX_WIDTH-1:0] output_index
`endif
);

    localparam logic [WORD_WIDTH-1:0] ONE = WORD_WIDTH'(1);

    state_e                state_q, state_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic [WORD_WIDTH-1:0] residual_q, residual_d;
    logic                  last_q, last_d;

    logic                  accept;
    logic                  out_hs;
    logic                  advance;
    logic                  load;
    logic [WORD_WIDTH-1:0] residual_next;
    logic [WORD_WIDTH-1:0] op_src;
    logic [WORD_WIDTH-1:0] op_mask;
    mode_e                 op_mode;

    assign accept        = input_valid & input_ready;
    assign out_hs        = output_valid & output_ready;
    assign advance       = out_hs & ~last_q;
    assign load          = accept | advance;
    assign residual_next = residual_q & (residual_q - ONE);

    // A fresh accept and an iteration step share one ops instance; they never coincide.
    assign op_src  = accept ? input_word : residual_next;
    assign op_mode = accept ? mode_e'(input_mode) : MODE_ITERATE;

    bitmask_rightmost_bit_ops #(.WORD_WIDTH(WORD_WIDTH)) u_ops (
        .word_i (op_src),
        .mode_i (op_mode),
        .mask_o (op_mask)
    );

    // NOTE: sequential state uses non-blocking assignments; reset is asynchronous.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_BUSY;
            ST_BUSY: if (out_hs && last_q && !accept) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        output_valid = 1'b0;
        input_ready  = 1'b1;
        case (state_q)
            ST_IDLE: begin
                output_valid = 1'b0;
                input_ready  = 1'b1;
            end
            ST_BUSY: begin
                output_valid = 1'b1;
                input_ready  = output_ready & last_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        word_d     = word_q;
        last_d     = last_q;
        residual_d = residual_q;
        if (load) begin
            word_d     = op_mask;
            last_d     = (op_mode != MODE_ITERATE) || ((op_src & (op_src - ONE)) == '0);
            residual_d = (op_mode == MODE_ITERATE) ? op_src : '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            word_q     <= '0;
            last_q     <= 1'b0;
            residual_q <= '0;
        end else begin
            word_q     <= word_d;
            last_q     <= last_d;
            residual_q <= residual_d;
        end
    end

    assign output_word = word_q;
    assign output_last = last_q;

`ifdef BITMASK_ITERATOR_INDEX_EN
    // Position of the lowest set bit of the operand covers every mode's index definition.
    logic [WORD_WIDTH-1:0]  lowest;
    logic [INDEX_WIDTH-1:0] index_q, index_d;

    bitmask_rightmost_bit_ops #(.WORD_WIDTH(WORD_WIDTH)) u_isolate (
        .word_i (op_src),
        .mode_i (MODE_ISOLATE1),
        .mask_o (lowest)
    );

    always_comb begin
        index_d = index_q;
        if (load) begin
            index_d = '0;
            for (int i = 0; i < WORD_WIDTH; i++) begin
                if (lowest[i]) index_d = INDEX_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) index_q <= '0;
        else          index_q <= index_d;
    end

    assign output_index = index_q;
`endif

endmodule

// File: tb/tb_bitmask_rightmost_bit_iterator.sv
// Scoreboard bench: a bit-loop model queues expected outputs on every accept; a monitor pops on handshake.
module tb_bitmask_rightmost_bit_iterator;
    import bitmask_pkg::*;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         input_valid, input_ready, output_valid, output_ready, output_last;
    logic [W-1:0] input_word, output_word;
    logic [1:0]   input_mode;
`ifdef BITMASK_ITERATOR_INDEX_EN
    logic [$clog2(W)-1:0] output_index;
`endif

    typedef struct packed {
        logic [W-1:0] word;
        logic         last;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    bitmask_rightmost_bit_iterator #(.WORD_WIDTH(W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_word   (input_word),
        .input_mode   (input_mode),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_word  (output_word),
        .output_last  (output_last)
`ifdef BITMASK_ITERATOR_INDEX_EN
        ,
        .output_index (output_index)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_push(input logic [W-1:0] x, input logic [1:0] m);
        exp_t e;
        int   low = W;
        int   high = -1;
        for (int i = W - 1; i >= 0; i--) if (x[i]) low = i;
        for (int i = 0; i < W; i++) if (x[i]) high = i;
        e.word = '0;
        e.last = 1'b1;
        case (m)
            2'd0: begin
                for (int i = 0; i < W; i++) if (i < low) e.word[i] = 1'b1;
                sb.push_back(e);
            end
            2'd1: begin
                if (low < W) e.word[low] = 1'b1;
                sb.push_back(e);
            end
            2'd2: begin
                for (int i = 0; i < W; i++) if (i <= low) e.word[i] = 1'b1;
                sb.push_back(e);
            end
            default: begin
                if (high < 0) sb.push_back(e);
                for (int i = 0; i < W; i++) begin
                    if (x[i]) begin
                        e.word    = '0;
                        e.word[i] = 1'b1;
                        e.last    = (i == high);
                        sb.push_back(e);
                    end
                end
            end
        endcase
    endfunction

    always @(negedge clock) begin
        exp_t e;
        if (reset_n) begin
            if (output_valid && sb.size() == 0) check("spurious_out", output_valid, 0);
            if (output_valid && output_ready && sb.size() != 0) begin
                e = sb.pop_front();
                check("word", output_word, e.word);
                check("last", output_last, e.last);
            end
            if (input_valid && input_ready) model_push(input_word, input_mode);
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [1:0] m);
        int n = 0;
        bit acc = 0;
        input_valid = 1'b1;
        input_word  = x;
        input_mode  = m;
        while (!acc && n < 50) begin
            @(negedge clock);
            acc = input_ready;
            @(posedge clock);
            #1;
            n++;
        end
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        input_valid = 1'b0;
        while ((sb.size() != 0 || output_valid) && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 100) check("drain_timeout", 0, 1);
    endtask

    initial begin
        logic [W-1:0] b2b [4];
        b2b = '{8'b0101_1000, 8'b0000_0001, 8'b1000_0000, 8'b0011_0100};
        input_valid  = 1'b0;
        input_word   = '0;
        input_mode   = 2'd0;
        output_ready = 1'b1;

        #1;
        check("rst_valid", output_valid, 0);
        check("rst_word",  output_word,  0);
        check("rst_last",  output_last,  0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check("idle_ready", input_ready, 1);
        @(posedge clock);
        #1;

        // Single-result modes, latency one cycle after accept.
        for (int m = 0; m < 3; m++) begin
            send(8'b0101_1000, 2'(m));
            input_valid = 1'b0;
            @(negedge clock);
            check("lat1_valid", output_valid, 1);
            drain();
        end

        // Iterate with a consumer always ready: three consecutive outputs, then idle.
        send(8'b0101_1000, 2'd3);
        input_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("iter_valid", output_valid, 1);
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        check("iter_idle", output_valid, 0);
        drain();

        // Zero operands.
        send(8'h00, 2'd3); drain();
        send(8'h00, 2'd0); drain();
        send(8'h00, 2'd1); drain();

        // Consumer stalls mid-iteration: output frozen, new input refused.
        output_ready = 1'b0;
        send(8'b0101_1000, 2'd3);
        input_valid = 1'b1;
        input_word  = 8'hFF;
        input_mode  = 2'd0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("stall_valid", output_valid, 1);
            check("stall_word",  output_word,  8'b0000_1000);
            check("stall_last",  output_last,  0);
            check("stall_ready", input_ready,  0);
        end
        input_valid  = 1'b0;
        output_ready = 1'b1;
        drain();

        // Back-to-back single-result inputs: accepted every cycle, no bubble.
        input_valid = 1'b1;
        input_mode  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            input_word = b2b[i];
            @(negedge clock);
            check("b2b_ready", input_ready, 1);
            if (i > 0) check("b2b_valid", output_valid, 1);
            @(posedge clock);
            #1;
        end
        input_valid = 1'b0;
        @(negedge clock);
        check("b2b_tail_valid", output_valid, 1);
        drain();

        // Reset after the second output of an iteration discards the rest.
        send(8'b1111_0000, 2'd3);
        input_valid = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_valid", output_valid, 0);
        check("midrst_word",  output_word,  0);
        check("midrst_last",  output_last,  0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            check("postrst_valid", output_valid, 0);
            check("postrst_ready", input_ready,  1);
        end
        @(posedge clock);
        #1;

        send(8'b0110_0000, 2'd2);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
